// File: rtl/seq_adder.sv
// Multi-cycle ripple adder: sums CHUNK bits per clock behind a valid/ready handshake on each side.
// Optional feature macro: SEQ_ADDER_OVF_EN adds the two's-complement overflow output ovf.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [64:0]      ONES_65    = (65'd1 << CHUNK) - 65'd1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = ONES_65[WIDTH-1:0];

    generate
        if (WIDTH < 2 || WIDTH > 64 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("seq_adder: WIDTH must be 2..64 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  sum_reg, sum_next;
    logic              carry_reg, carry_next;

    logic [31:0]       shamt;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              msb_cin;
    logic              last_chunk;

    assign shamt      = 32'(cnt_reg) * 32'(CHUNK);
    assign a_chunk    = CHUNK'(a_reg >> shamt);
    assign b_chunk    = CHUNK'(b_reg >> shamt);
    assign last_chunk = (cnt_reg == CW'(N - 1));

    // Each cell owns its carry nets so the chain is a plain feed-forward ripple.
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            logic ci;
            logic co;
            if (gi == 0) begin : g_first
                assign ci = carry_reg;
            end else begin : g_next
                assign ci = g_fa[gi-1].co;
            end
            assign chunk_sum[gi] = a_chunk[gi] ^ b_chunk[gi] ^ ci;
            assign co            = (a_chunk[gi] & b_chunk[gi]) | (ci & (a_chunk[gi] ^ b_chunk[gi]));
        end
    endgenerate

    assign chunk_cout = g_fa[CHUNK-1].co;
    assign msb_cin    = g_fa[CHUNK-1].ci;

`ifdef SEQ_ADDER_OVF_EN
    logic ovf_reg, ovf_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
`ifdef SEQ_ADDER_OVF_EN
        ovf_next   = ovf_reg;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    cnt_next   = '0;
                    state_next = ADD;
                end
            end
            ADD: begin
                // Merge this chunk's result into its slot, leaving other chunks untouched.
                sum_next   = (sum_reg & ~(CHUNK_MASK << shamt)) | (WIDTH'(chunk_sum) << shamt);
                carry_next = chunk_cout;
                if (last_chunk) begin
`ifdef SEQ_ADDER_OVF_EN
                    ovf_next   = msb_cin ^ chunk_cout;
`endif
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifndef SEQ_ADDER_OVF_EN
    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;
`endif

    assign sum  = sum_reg;
    assign cout = carry_reg;

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: an 8-bit/2-bit-chunk instance and an 8-bit single-chunk instance.
module tb_seq_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid0, in_ready0, cin0, out_valid0, out_ready0, cout0;
    logic [7:0] a0, b0, sum0;
    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [7:0] a1, b1, sum1;
`ifdef SEQ_ADDER_OVF_EN
    logic       ovf0, ovf1;
`endif

    int checks   = 0;
    int failures = 0;

    seq_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .cin(cin0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .cout(cout0)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf0)
`endif
    );

    seq_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge following the accept edge; lat = edges after accept until out_valid.
    task automatic wait_done0(output int lat);
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a0 = ta; b0 = tb; cin0 = tc; in_valid0 = 1'b1;
        check_val({tag, ".in_ready"}, 64'(in_ready0), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
        wait_done0(lat);
        check_val({tag, ".latency"}, 64'(lat), 64'd4);
        check_val({tag, ".sum"}, 64'(sum0), 64'(es));
        check_val({tag, ".cout"}, 64'(cout0), 64'(ec));
`ifdef SEQ_ADDER_OVF_EN
        check_val({tag, ".ovf"}, 64'(ovf0), 64'(eo));
`endif
        $display("op %s: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d lat=%0d (exp sum=0x%02h cout=%0d ovf=%0d)",
                 tag, ta, tb, tc, sum0, cout0, lat, es, ec, eo);
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        check_val({tag, ".back_idle"}, 64'(in_ready0), 64'd1);
        check_val({tag, ".ov_low"}, 64'(out_valid0), 64'd0);
    endtask

    initial begin
        int  lat;
        logic seen;
        rst_n = 1'b0;
        in_valid0 = 0; a0 = 0; b0 = 0; cin0 = 0; out_ready0 = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 0;
        #1;
        check_val("rst.in_ready", 64'(in_ready0), 64'd1);
        check_val("rst.out_valid", 64'(out_valid0), 64'd0);
        check_val("rst.sum", 64'(sum0), 64'd0);
        check_val("rst.cout", 64'(cout0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("ff_p1",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op("7f_p1",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("80_ff",   8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
        do_op("3c_0f",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        do_op("c8_64",   8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);

        // Stall in DONE with a new operand set waiting on in_valid throughout.
        @(negedge clk);
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0; in_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a0 = 8'h55; b0 = 8'h11;
        wait_done0(lat);
        check_val("stall.latency", 64'(lat), 64'd4);
        check_val("stall.sum", 64'(sum0), 64'h46);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall.sum_hold", 64'(sum0), 64'h46);
            check_val("stall.cout_hold", 64'(cout0), 64'd0);
            check_val("stall.in_ready", 64'(in_ready0), 64'd0);
            check_val("stall.ov_hold", 64'(out_valid0), 64'd1);
        end
        $display("op stall: a=0x12 b=0x34 held sum=0x%02h for 5 cycles", sum0);
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        check_val("stall.post_hs_ov", 64'(out_valid0), 64'd0);
        check_val("stall.post_hs_ready", 64'(in_ready0), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid0 = 1'b0;
        wait_done0(lat);
        check_val("second.latency", 64'(lat), 64'd4);
        check_val("second.sum", 64'(sum0), 64'h66);
        check_val("second.cout", 64'(cout0), 64'd0);
        $display("op second: a=0x55 b=0x11 -> sum=0x%02h lat=%0d", sum0, lat);
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;

        // Asynchronous reset during the second ADD cycle.
        @(negedge clk);
        a0 = 8'h77; b0 = 8'h11; cin0 = 1'b0; in_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid0 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst.in_ready", 64'(in_ready0), 64'd1);
        check_val("midrst.sum", 64'(sum0), 64'd0);
        check_val("midrst.cout", 64'(cout0), 64'd0);
        check_val("midrst.out_valid", 64'(out_valid0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid0) seen = 1'b1;
        end
        check_val("midrst.no_ov", 64'(seen), 64'd0);
        $display("op midrst: reset in 2nd ADD cycle, out_valid seen=%0d", seen);
        do_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Single-chunk instance.
        @(negedge clk);
        a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1; in_valid1 = 1'b1;
        check_val("w8.in_ready", 64'(in_ready1), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val("w8.latency", 64'(lat), 64'd1);
        check_val("w8.sum", 64'(sum1), 64'h01);
        check_val("w8.cout", 64'(cout1), 64'd1);
`ifdef SEQ_ADDER_OVF_EN
        check_val("w8.ovf", 64'(ovf1), 64'd1);
`endif
        $display("op w8: a=0x80 b=0x80 cin=1 -> sum=0x%02h cout=%0d lat=%0d", sum1, cout1, lat);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check_val("w8.back_idle", 64'(in_ready1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits, legal range 2..64.
REQ-002 SHALL have parameter CHUNK, default 2: bits added per cycle; WIDTH mod CHUNK = 0 is required, and an illegal value SHALL stop elaboration.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b, cin are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have port a, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-010 SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: result bits (a+b+cin) mod 2^WIDTH.
REQ-013 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, ADD, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept is defined as in_valid&&in_ready at a rising edge; on accept SHALL latch a, b, cin, clear chunk counter to 0, and go to ADD.
REQ-017 Each ADD cycle SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) of A and B plus the running carry, using a ripple chain of CHUNK full-adder cells, write the result into sum bits of chunk k, and update the running carry.
REQ-018 After chunk N-1 (N=WIDTH/CHUNK) is added, SHALL go to DONE; out_valid SHALL rise exactly N cycles after the accept edge.
REQ-019 In DONE, sum and cout SHALL hold stable until out_valid&&out_ready, then SHALL return to IDLE.
REQ-020 No accept SHALL occur in the cycle of the output handshake; minimum initiation interval is N+1 cycles (N+2 with the idle cycle).
REQ-021 in_valid asserted in ADD or DONE SHALL be ignored; latched operands SHALL NOT change.
REQ-022 out_ready held low SHALL stall indefinitely in DONE without data loss.
REQ-023 With CHUNK=WIDTH, SHALL give a 1-cycle ADD phase with identical results.
REQ-024 sum bits of chunks not yet processed are don't-care while out_valid=0.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, force state IDLE, counter 0, sum 0, cout 0, latched operands 0, and ovf 0 when present.
REQ-026 rst_n asserted mid-ADD or in DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-027 After reset, in_ready=1 and out_valid=0.

Configuration
REQ-028 Macro SEQ_ADDER_OVF_EN defined: SHALL add output port ovf, 1 bit, the two's-complement overflow (carry into MSB XOR carry out of MSB), valid and held with out_valid.
REQ-029 SEQ_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-030 a=0x00, b=0x00, cin=0 accepted -> out_valid rises 4 cycles later with sum=0x00, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-032 Macro SEQ_ADDER_OVF_EN defined: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0xFF -> sum=0x7F, cout=1, ovf=1.
REQ-033 out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout held, in_ready=0, second operand set accepted only after the output handshake plus one cycle.
REQ-034 rst_n pulsed low during the 2nd ADD cycle -> in_ready=1, sum=0 immediately, no out_valid; a following op 0x10+0x20 -> sum=0x30.
REQ-035 WIDTH=8, CHUNK=8, a=0x80, b=0x80, cin=1 -> out_valid 1 cycle after accept, sum=0x01, cout=1.
